// File: rtl/lake_traffic_pkg.sv
// Shared types and constants for the lake port traffic engine.
// Mode and state encodings, LFSR polynomial/seed, and the offer-gate helper.
package lake_traffic_pkg;

  typedef enum logic [1:0] {
    MODE_ALWAYS = 2'd0,
    MODE_RANDOM = 2'd1,
    MODE_ALT    = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Unused encoding 3 behaves like MODE_ALWAYS.
  function automatic logic mode_gate(input logic [1:0] mode, input logic rnd, input logic alt);
    case (mode)
      MODE_RANDOM: mode_gate = rnd;
      MODE_ALT:    mode_gate = alt;
      default:     mode_gate = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lake_traffic_lfsr.sv
// 16-bit Galois LFSR with a per-instance seed; advances only while enabled.
// Only the low bit is exported, it drives the random offer/ready gate.
module lake_traffic_lfsr
  import lake_traffic_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rnd
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  assign rnd = lfsr_q[0];

endmodule

// File: rtl/lake_port_traffic.sv
// Ready/valid traffic engine: arithmetic producers, backpressuring checkers and run FSM.
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | traffic active, cycle_count advancing
// DONE  | run ended (done or timeout), results held until the next start
module lake_port_traffic
  import lake_traffic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2,
  parameter int CNT_WIDTH  = 16,
  parameter int CYC_WIDTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_WR*DATA_WIDTH-1:0] cfg_wr_base,
  input  logic [NUM_WR*DATA_WIDTH-1:0] cfg_wr_stride,
  input  logic [NUM_WR*2-1:0]          cfg_wr_mode,
  input  logic [NUM_RD*DATA_WIDTH-1:0] cfg_rd_base,
  input  logic [NUM_RD*DATA_WIDTH-1:0] cfg_rd_stride,
  input  logic [NUM_RD*2-1:0]          cfg_rd_mode,
  input  logic [NUM_RD*CNT_WIDTH-1:0]  cfg_rd_delay,
  input  logic [CNT_WIDTH-1:0]         cfg_rd_target,
  input  logic [CYC_WIDTH-1:0]         cfg_max_cycles,
  output logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WR-1:0]            wr_valid,
  input  logic [NUM_WR-1:0]            wr_ready,
  input  logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [CYC_WIDTH-1:0]         cycle_count,
  output logic [NUM_RD*CNT_WIDTH-1:0]  rd_count,
  output logic [NUM_RD-1:0]            mismatch,
  output logic [NUM_RD*CNT_WIDTH-1:0]  first_err_idx
);

  state_e            state;
  logic              run, run_enter, run_exit, hit_limit;
  logic [NUM_RD-1:0] reached;

  assign run       = (state == RUN);
  assign run_enter = (state != RUN) && start;
  assign hit_limit = (cycle_count == cfg_max_cycles);
  assign run_exit  = run && ((&reached) || hit_limit);

  // Completion takes priority over the cycle limit when both land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        RUN: begin
          if (&reached) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (hit_limit) begin
            state   <= DONE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            cycle_count <= cycle_count + CYC_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_WR; k++) begin : gen_wr
    logic                  rnd, alt, valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    lake_traffic_lfsr #(.SEED(LFSR_SEED ^ 16'(k))) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (run),
      .rnd (rnd)
    );

    // The gate only decides when to raise valid; a pending offer is held until taken.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        alt     <= 1'b0;
      end else if (run_enter) begin
        valid_q <= 1'b0;
        data_q  <= cfg_wr_base[k*DATA_WIDTH +: DATA_WIDTH];
        alt     <= 1'b1;
      end else if (run) begin
        alt <= ~alt;
        if (valid_q && wr_ready[k]) begin
          data_q <= data_q + cfg_wr_stride[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (run_exit) begin
          valid_q <= 1'b0;
        end else if (!valid_q || wr_ready[k]) begin
          valid_q <= mode_gate(cfg_wr_mode[2*k +: 2], rnd, alt);
        end
      end
    end

    assign wr_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign wr_valid[k] = valid_q;
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : gen_rd
    logic                  rnd, alt, hs, mis_q, sat;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_nxt, err_q;
    logic [DATA_WIDTH-1:0] exp_q;

    lake_traffic_lfsr #(.SEED(LFSR_SEED ^ 16'(NUM_WR + j))) u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (run),
      .rnd (rnd)
    );

    assign rd_ready[j] = run
                       && (cycle_count > CYC_WIDTH'(cfg_rd_delay[j*CNT_WIDTH +: CNT_WIDTH]))
                       && mode_gate(cfg_rd_mode[2*j +: 2], rnd, alt);
    assign hs      = rd_valid[j] && rd_ready[j];
    assign sat     = (cnt_q == {CNT_WIDTH{1'b1}});
    assign cnt_nxt = (hs && !sat) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    // Look at the post-handshake count so the run stops on the accepting edge.
    assign reached[j] = (cnt_nxt >= cfg_rd_target);

    // exp_q tracks base + count*stride and freezes with the count at saturation.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        err_q <= '0;
        mis_q <= 1'b0;
        exp_q <= '0;
        alt   <= 1'b0;
      end else if (run_enter) begin
        cnt_q <= '0;
        err_q <= '0;
        mis_q <= 1'b0;
        exp_q <= cfg_rd_base[j*DATA_WIDTH +: DATA_WIDTH];
        alt   <= 1'b1;
      end else if (run) begin
        alt   <= ~alt;
        cnt_q <= cnt_nxt;
        if (hs && !sat) begin
          exp_q <= exp_q + cfg_rd_stride[j*DATA_WIDTH +: DATA_WIDTH];
        end
        if (hs && !mis_q && (rd_data[j*DATA_WIDTH +: DATA_WIDTH] != exp_q)) begin
          mis_q <= 1'b1;
          err_q <= cnt_q;
        end
      end
    end

    assign rd_count[j*CNT_WIDTH +: CNT_WIDTH]      = cnt_q;
    assign first_err_idx[j*CNT_WIDTH +: CNT_WIDTH] = err_q;
    assign mismatch[j] = mis_q;
  end

endmodule

// File: tb/tb_lake_port_traffic.sv
// Loopback bench: each producer feeds its consumer through a 2-deep FIFO model,
// with a scoreboard of expected arithmetic words and directed run scenarios.
module tb_lake_port_traffic;
  localparam int DW = 16;
  localparam int NW = 2;
  localparam int NR = 2;
  localparam int CW = 16;
  localparam int YW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [NW*DW-1:0] cfg_wr_base, cfg_wr_stride;
  logic [NW*2-1:0]  cfg_wr_mode;
  logic [NR*DW-1:0] cfg_rd_base, cfg_rd_stride;
  logic [NR*2-1:0]  cfg_rd_mode;
  logic [NR*CW-1:0] cfg_rd_delay;
  logic [CW-1:0]    cfg_rd_target;
  logic [YW-1:0]    cfg_max_cycles;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_valid, wr_ready;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid, rd_ready;
  logic             busy, done, timeout;
  logic [YW-1:0]    cycle_count;
  logic [NR*CW-1:0] rd_count, first_err_idx;
  logic [NR-1:0]    mismatch;

  int passed = 0;
  int total = 0;
  logic block = 1'b0;
  int cor_a = -1;
  int cor_b = -1;

  logic [15:0] fmem [2][2];
  int fcnt [2];
  int npop [2];

  logic [15:0] sbq0 [$];
  logic [15:0] sbq1 [$];
  int nwr [2];
  logic pend [2];
  logic [15:0] pdata [2];

  lake_port_traffic #(.DATA_WIDTH(DW), .NUM_WR(NW), .NUM_RD(NR), .CNT_WIDTH(CW), .CYC_WIDTH(YW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_wr_base(cfg_wr_base), .cfg_wr_stride(cfg_wr_stride), .cfg_wr_mode(cfg_wr_mode),
    .cfg_rd_base(cfg_rd_base), .cfg_rd_stride(cfg_rd_stride), .cfg_rd_mode(cfg_rd_mode),
    .cfg_rd_delay(cfg_rd_delay), .cfg_rd_target(cfg_rd_target), .cfg_max_cycles(cfg_max_cycles),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
    .rd_count(rd_count), .mismatch(mismatch), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    wr_ready = '0;
    rd_valid = '0;
    rd_data  = '0;
    for (int c = 0; c < 2; c++) begin
      wr_ready[c] = !block && (fcnt[c] < 2);
      rd_valid[c] = !block && (fcnt[c] != 0);
      rd_data[c*DW +: DW] = fmem[c][0] ^ {15'd0, (c == 0) && ((npop[0] == cor_a) || (npop[0] == cor_b))};
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        fcnt[c] <= 0;
        npop[c] <= 0;
        fmem[c][0] <= '0;
        fmem[c][1] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (wr_valid[c] && wr_ready[c] && rd_valid[c] && rd_ready[c]) begin
          if (fcnt[c] == 1) fmem[c][0] <= wr_data[c*DW +: DW];
          else begin
            fmem[c][0] <= fmem[c][1];
            fmem[c][1] <= wr_data[c*DW +: DW];
          end
        end else if (wr_valid[c] && wr_ready[c]) begin
          if (fcnt[c] == 0) fmem[c][0] <= wr_data[c*DW +: DW];
          else fmem[c][1] <= wr_data[c*DW +: DW];
          fcnt[c] <= fcnt[c] + 1;
        end else if (rd_valid[c] && rd_ready[c]) begin
          fmem[c][0] <= fmem[c][1];
          fcnt[c] <= fcnt[c] - 1;
        end
        if (rd_valid[c] && rd_ready[c]) npop[c] <= npop[c] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, want);
  endtask

  // Scoreboard: push base+n*stride on each producer handshake, pop on each consumer handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        logic [15:0] want;
        if (busy && pend[c])
          check("valid_hold", 64'({wr_valid[c], wr_data[c*DW +: DW]}), 64'({1'b1, pdata[c]}));
        pend[c] = wr_valid[c] && !wr_ready[c];
        pdata[c] = wr_data[c*DW +: DW];
        if (wr_valid[c] && wr_ready[c]) begin
          want = cfg_wr_base[c*DW +: DW] + 16'(nwr[c]) * cfg_wr_stride[c*DW +: DW];
          if (c == 0) sbq0.push_back(want);
          else sbq1.push_back(want);
          nwr[c]++;
        end
        if (rd_valid[c] && rd_ready[c]) begin
          if ((c == 0 && sbq0.size() == 0) || (c == 1 && sbq1.size() == 0)) begin
            check("sb_underflow", 64'(0), 64'(1));
          end else begin
            want = (c == 0) ? sbq0.pop_front() : sbq1.pop_front();
            check("sb_data", 64'(fmem[c][0]), 64'(want));
          end
        end
      end
    end
  end

  task automatic clear_sb();
    sbq0.delete();
    sbq1.delete();
    for (int c = 0; c < 2; c++) begin
      nwr[c] = 0;
      pend[c] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_start();
    clear_sb();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || timeout) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(done || timeout)) check("wait_end_bound", 64'(0), 64'(1));
  endtask

  task automatic wait_cc(input int cc, input int budget);
    int n = 0;
    while (cycle_count != 64'(cc) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cycle_count != 64'(cc)) check("wait_cc_bound", 64'(0), 64'(1));
  endtask

  task automatic set_cfg(input logic [3:0] wmode, input logic [3:0] rmode, input logic [15:0] dly0,
                         input logic [15:0] target, input logic [63:0] maxc);
    cfg_wr_base    = {16'd100, 16'd0};
    cfg_wr_stride  = {16'd3, 16'd2};
    cfg_rd_base    = {16'd100, 16'd0};
    cfg_rd_stride  = {16'd3, 16'd2};
    cfg_wr_mode    = wmode;
    cfg_rd_mode    = rmode;
    cfg_rd_delay   = {16'd0, dly0};
    cfg_rd_target  = target;
    cfg_max_cycles = maxc;
  endtask

  initial begin
    int viol;
    set_cfg(4'b0000, 4'b0000, 16'd0, 16'd100, 64'd5000);
    do_reset();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_flags", 64'({done, timeout, mismatch}), 64'(0));
    check("rst_wr_valid", 64'(wr_valid), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_rd_ready", 64'(rd_ready), 64'(0));
    check("rst_cycle_count", cycle_count, 64'(0));
    check("rst_rd_count", 64'(rd_count), 64'(0));
    check("rst_err_idx", 64'(first_err_idx), 64'(0));

    // Plain loopback, target 100.
    run_start();
    check("t1_busy", 64'(busy), 64'(1));
    wait_end(1000);
    check("t1_done", 64'({done, timeout}), 64'(2'b10));
    check("t1_rd_count0", 64'(rd_count[15:0]), 64'(100));
    check("t1_rd_count1", 64'(rd_count[31:16]), 64'(100));
    check("t1_mismatch", 64'(mismatch), 64'(0));
    check("t1_cycle_count", cycle_count, 64'(101));
    check("t1_idle_outputs", 64'({busy, wr_valid, rd_ready}), 64'(0));

    // Consumer 0 held off until cycle_count passes 64.
    set_cfg(4'b0000, 4'b0000, 16'd64, 16'd100, 64'd5000);
    do_reset();
    run_start();
    viol = 0;
    for (int i = 0; i < 200 && cycle_count <= 64'd64; i++) begin
      if (rd_ready[0]) viol++;
      if (cycle_count == 64'd60) begin
        check("t2_stall_valid", 64'(wr_valid[0]), 64'(1));
        check("t2_stall_data", 64'(wr_data[15:0]), 64'(4));
      end
      @(negedge clk);
    end
    check("t2_ready_low", 64'(viol), 64'(0));
    check("t2_release_cc", cycle_count, 64'(65));
    check("t2_ready_after", 64'(rd_ready[0]), 64'(1));
    wait_end(1000);
    check("t2_done", 64'({done, timeout}), 64'(2'b10));
    check("t2_rd_count0", 64'(rd_count[15:0]), 64'(100));
    check("t2_mismatch", 64'(mismatch), 64'(0));

    // Random offer and ready on every channel.
    set_cfg(4'b0101, 4'b0101, 16'd0, 16'd500, 64'd5000);
    do_reset();
    run_start();
    wait_end(6000);
    check("t3_done", 64'({done, timeout}), 64'(2'b10));
    check("t3_mismatch", 64'(mismatch), 64'(0));
    check("t3_count0", 64'(rd_count[15:0] >= 16'd500), 64'(1));
    check("t3_count1", 64'(rd_count[31:16] >= 16'd500), 64'(1));

    // Corrupt words 37 and 80 on channel 0.
    set_cfg(4'b0000, 4'b0000, 16'd0, 16'd100, 64'd5000);
    cor_a = 37;
    cor_b = 80;
    do_reset();
    run_start();
    wait_end(1000);
    check("t4_done", 64'(done), 64'(1));
    check("t4_mismatch", 64'(mismatch), 64'(2'b01));
    check("t4_first_err0", 64'(first_err_idx[15:0]), 64'(37));
    check("t4_first_err1", 64'(first_err_idx[31:16]), 64'(0));
    cor_a = -1;
    cor_b = -1;

    // Silent DUT: cycle limit, then a restart from DONE.
    set_cfg(4'b0000, 4'b0000, 16'd0, 16'd100, 64'd50);
    block = 1'b1;
    do_reset();
    run_start();
    wait_end(200);
    check("t5_flags", 64'({done, timeout}), 64'(2'b01));
    check("t5_cycle_count", cycle_count, 64'(50));
    check("t5_rd_count", 64'(rd_count), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    block = 1'b0;
    cfg_rd_target  = 16'd10;
    cfg_max_cycles = 64'd5000;
    run_start();
    check("t5_restart_cc", cycle_count, 64'(0));
    check("t5_restart_flags", 64'({busy, done, timeout}), 64'(3'b100));
    wait_end(300);
    check("t5_restart_done", 64'({done, timeout}), 64'(2'b10));
    check("t5_restart_count", 64'(rd_count[15:0]), 64'(10));

    // Reset mid-run.
    set_cfg(4'b0000, 4'b0000, 16'd0, 16'd100, 64'd5000);
    do_reset();
    run_start();
    wait_cc(20, 100);
    check("t6_pre_count", 64'(rd_count[15:0] != 16'd0), 64'(1));
    rst = 1'b1;
    #1;
    check("t6_flags", 64'({busy, done, timeout, mismatch}), 64'(0));
    check("t6_handshake", 64'({wr_valid, rd_ready}), 64'(0));
    check("t6_counts", 64'(rd_count), 64'(0));
    check("t6_cycle_count", cycle_count, 64'(0));
    check("t6_wr_data", 64'(wr_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    clear_sb();
    repeat (10) @(negedge clk);
    check("t6_quiet", 64'({busy, wr_valid, rd_ready}), 64'(0));
    check("t6_quiet_cc", cycle_count, 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
